fc_layer_sequencer: RTL and testbench

- Sequences one fully-connected layer built from fc_neuron instances that share one weight-address bus.
- Accepts an input vector of PREVIOUS_LAYER_HEIGHT words from the previous layer over a valid/ready stream.
- Drives the shared neuron control (mem_addr, data, sum_en, add_bias, neuron reset).
- Presents a single "layer result ready" handshake to the next layer and clears the accumulators after it is consumed.

---
 rtl/fc_seq_pkg.sv | 16 +
 rtl/fc_layer_sequencer.sv | 151 +++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_seq_pkg.sv
// Shared state encoding and address sizing for the fully-connected layer sequencer.
package fc_seq_pkg;

   typedef enum logic [2:0] {
      ACCUM = 3'd0,
      BIAS  = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      CLEAR = 3'd4
   } state_t;

   function automatic int unsigned addr_width(input int unsigned h);
      return $clog2(h + 1);
   endfunction

endpackage

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer: streams the input vector, adds bias, hands off the result.
// Optional stall/vector performance counters are built when FC_LAYER_SEQ_PERF_EN is defined.
module fc_layer_sequencer
   import fc_seq_pkg::*;
#(
   parameter int unsigned WORD_SIZE             = 16,
   parameter int unsigned PREVIOUS_LAYER_HEIGHT = 4,
   parameter int unsigned LU_LATENCY            = 1
) (
   input  logic                                         clk_i,
   input  logic                                         reset_n_i,
   input  logic [WORD_SIZE-1:0]                         data_i,
   input  logic                                         valid_i,
   output logic                                         ready_o,
   output logic [addr_width(PREVIOUS_LAYER_HEIGHT)-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0]                         data_o,
   output logic                                         sum_en_o,
   output logic                                         add_bias_o,
   output logic                                         neuron_reset_o,
   output logic                                         valid_o,
   input  logic                                         ready_i,
   output logic                                         busy_o
`ifdef FC_LAYER_SEQ_PERF_EN
   ,
   output logic [31:0]                                  stall_cnt_o,
   output logic [15:0]                                  vec_cnt_o
`endif
);

   localparam int unsigned   AW        = addr_width(PREVIOUS_LAYER_HEIGHT);
   localparam int unsigned   LW        = (LU_LATENCY > 1) ? $clog2(LU_LATENCY) : 1;
   localparam logic [AW-1:0] CNT_LAST  = AW'(PREVIOUS_LAYER_HEIGHT - 1);
   localparam logic [AW-1:0] BIAS_ADDR = AW'(PREVIOUS_LAYER_HEIGHT);
   localparam logic [LW-1:0] LAT_LAST  = LW'(LU_LATENCY - 1);

   state_t               r_state, w_state_nxt;
   logic [AW-1:0]        r_cnt, w_cnt_nxt;
   logic [LW-1:0]        r_lat, w_lat_nxt;
   logic [WORD_SIZE-1:0] r_data;
   logic                 r_sum_en;
   logic                 r_add_bias;
   logic                 r_valid, w_valid_nxt;
   logic                 w_accept;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lat_nxt   = r_lat;
      w_valid_nxt = r_valid;
      w_accept    = 1'b0;
      ready_o     = 1'b0;
      mem_addr_o  = '0;
      unique case (r_state)
         ACCUM: begin
            ready_o    = 1'b1;
            mem_addr_o = r_cnt;
            w_accept   = valid_i;
            if (valid_i) begin
               if (r_cnt == CNT_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = BIAS;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         BIAS: begin
            mem_addr_o  = BIAS_ADDR;
            w_state_nxt = WAIT;
            w_lat_nxt   = '0;
         end
         WAIT: begin
            // lat == 0 coincides with the add_bias pulse
            if (r_lat == LAT_LAST) begin
               w_state_nxt = DONE;
               w_valid_nxt = 1'b1;
               w_lat_nxt   = '0;
            end else begin
               w_lat_nxt = r_lat + 1'b1;
            end
         end
         DONE: begin
            if (ready_i) begin
               w_state_nxt = CLEAR;
               w_valid_nxt = 1'b0;
            end
         end
         CLEAR: begin
            w_state_nxt = ACCUM;
            w_cnt_nxt   = '0;
         end
         default: w_state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state    <= ACCUM;
         r_cnt      <= '0;
         r_lat      <= '0;
         r_data     <= '0;
         r_sum_en   <= 1'b0;
         r_add_bias <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_lat      <= w_lat_nxt;
         r_sum_en   <= w_accept;
         r_add_bias <= (r_state == BIAS);
         r_valid    <= w_valid_nxt;
         if (w_accept) begin
            r_data <= data_i;
         end
      end
   end

   assign data_o         = r_data;
   assign sum_en_o       = r_sum_en;
   assign add_bias_o     = r_add_bias;
   assign valid_o        = r_valid;
   assign busy_o         = (r_state != ACCUM) || (r_cnt != '0);
   // Neurons must also be held clear while the sequencer itself is in reset.
   assign neuron_reset_o = !reset_n_i || (r_state == CLEAR);

`ifdef FC_LAYER_SEQ_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [15:0] r_vec_cnt;
   logic        w_stall;

   assign w_stall = ((r_state == ACCUM) && busy_o && !valid_i) || ((r_state == DONE) && !ready_i);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_stall_cnt <= '0;
         r_vec_cnt   <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (r_valid && ready_i) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
         end
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign vec_cnt_o   = r_vec_cnt;
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench: drivers queue expected events with their cycles, a negedge monitor matches them.
module tb_fc_layer_sequencer;

   localparam int K_ACC   = 0;
   localparam int K_SUM   = 1;
   localparam int K_BADDR = 2;
   localparam int K_BIAS  = 3;
   localparam int K_VRISE = 4;
   localparam int K_HS    = 5;
   localparam int K_CLR   = 6;

   typedef struct {
      int dut;
      int kind;
      int cyc;
      int val;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   logic prev_v[2];

   // dut0: H=4, LU_LATENCY=1
   logic [15:0] dat4 = '0;
   logic        v4 = 1'b0, r4 = 1'b0;
   logic        rdy4, se4, ab4, nr4, vo4, bsy4;
   logic [2:0]  mem4;
   logic [15:0] do4;
   // dut1: H=1, LU_LATENCY=3
   logic [15:0] dat1 = '0;
   logic        v1 = 1'b0, r1 = 1'b0;
   logic        rdy1, se1, ab1, nr1, vo1, bsy1;
   logic [0:0]  mem1;
   logic [15:0] do1;
`ifdef FC_LAYER_SEQ_PERF_EN
   logic [31:0] st4, st1;
   logic [15:0] vc4, vc1;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fc_layer_sequencer #(
      .WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(4), .LU_LATENCY(1)
   ) u_dut4 (
      .clk_i(clk), .reset_n_i(rst_n), .data_i(dat4), .valid_i(v4), .ready_o(rdy4),
      .mem_addr_o(mem4), .data_o(do4), .sum_en_o(se4), .add_bias_o(ab4),
      .neuron_reset_o(nr4), .valid_o(vo4), .ready_i(r4), .busy_o(bsy4)
`ifdef FC_LAYER_SEQ_PERF_EN
      , .stall_cnt_o(st4), .vec_cnt_o(vc4)
`endif
   );

   fc_layer_sequencer #(
      .WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(1), .LU_LATENCY(3)
   ) u_dut1 (
      .clk_i(clk), .reset_n_i(rst_n), .data_i(dat1), .valid_i(v1), .ready_o(rdy1),
      .mem_addr_o(mem1), .data_o(do1), .sum_en_o(se1), .add_bias_o(ab1),
      .neuron_reset_o(nr1), .valid_o(vo1), .ready_i(r1), .busy_o(bsy1)
`ifdef FC_LAYER_SEQ_PERF_EN
      , .stall_cnt_o(st1), .vec_cnt_o(vc1)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
      end
   endtask

   function automatic string kname(input int k);
      case (k)
         K_ACC:   return "accept";
         K_SUM:   return "sum_en";
         K_BADDR: return "bias_addr";
         K_BIAS:  return "add_bias";
         K_VRISE: return "valid_rise";
         K_HS:    return "out_handshake";
         default: return "neuron_clear";
      endcase
   endfunction

   task automatic push(input int d, input int k, input int c, input int v);
      exp_t e;
      e.dut = d; e.kind = k; e.cyc = c; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic expect_evt(input int d, input int k, input int v);
      int   idx[$];
      exp_t e;
      idx = exp_q.find_first_index with (item.dut == d && item.kind == k);
      n_checks++;
      if (idx.size() == 0) begin
         n_fail++;
         $display("FAIL dut%0d unexpected %s at cycle %0d value %0d, required no event",
                  d, kname(k), cyc, v);
      end else begin
         e = exp_q[idx[0]];
         exp_q.delete(idx[0]);
         if (e.cyc != cyc || e.val != v) begin
            n_fail++;
            $display("FAIL dut%0d %s: cycle %0d value %0d, required cycle %0d value %0d",
                     d, kname(k), cyc, v, e.cyc, e.val);
         end
      end
   endtask

   task automatic mon(input int d, input int h, input logic rdy, input logic vld, input int addr,
                      input int dat, input logic se, input logic ab, input logic nr,
                      input logic bsy, input logic rdi, input logic vin);
      string p;
      p = $sformatf("dut%0d", d);
      if (!rst_n) begin
         chk({p, " rst ready_o"}, int'(rdy), 1);
         chk({p, " rst mem_addr_o"}, addr, 0);
         chk({p, " rst data_o"}, dat, 0);
         chk({p, " rst sum_en_o"}, int'(se), 0);
         chk({p, " rst add_bias_o"}, int'(ab), 0);
         chk({p, " rst valid_o"}, int'(vld), 0);
         chk({p, " rst busy_o"}, int'(bsy), 0);
         chk({p, " rst neuron_reset_o"}, int'(nr), 1);
         prev_v[d] = 1'b0;
      end else begin
         chk({p, " addr_range"}, int'(addr <= h), 1);
         if (vin && rdy) expect_evt(d, K_ACC, addr);
         if (se) expect_evt(d, K_SUM, dat);
         if (addr == h) expect_evt(d, K_BADDR, addr);
         if (ab) begin
            expect_evt(d, K_BIAS, 0);
            chk({p, " wait mem_addr_o"}, addr, 0);
         end
         if (vld && !prev_v[d]) expect_evt(d, K_VRISE, 0);
         if (vld) chk({p, " done ready_o"}, int'(rdy), 0);
         if (vld && rdi) expect_evt(d, K_HS, 0);
         if (nr) begin
            expect_evt(d, K_CLR, 0);
            chk({p, " clear ready_o"}, int'(rdy), 0);
         end
         prev_v[d] = vld;
      end
   endtask

   always @(negedge clk) begin
      mon(0, 4, rdy4, vo4, int'(mem4), int'(do4), se4, ab4, nr4, bsy4, r4, v4);
      mon(1, 1, rdy1, vo1, int'(mem1), int'(do1), se1, ab1, nr1, bsy1, r1, v1);
`ifdef FC_LAYER_SEQ_PERF_EN
      if (!rst_n) begin
         chk("rst stall_cnt_o", int'(st4), 0);
         chk("rst vec_cnt_o", int'(vc4), 0);
      end
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic v, input int w, input logic r);
      if (d == 0) begin
         v4 = v; dat4 = 16'(w); r4 = r;
      end else begin
         v1 = v; dat1 = 16'(w); r1 = r;
      end
   endtask

   // One vector: optional input gap after word gap_idx, output stall of 'stall' cycles in DONE.
   // stall == 0 keeps ready_i high for the whole vector.
   task automatic send_vec(input int d, input int h, input int lat, input int w[4],
                           input int gap_idx, input int gap_len, input int stall, input bit pulse);
      int t, tl, tv, ths;
      t  = cyc;
      tl = t;
      for (int i = 0; i < h; i++) begin
         push(d, K_ACC, t, i);
         push(d, K_SUM, t + 1, w[i] & 16'hFFFF);
         tl = t;
         t++;
         if (i == gap_idx) t += gap_len;
      end
      push(d, K_BADDR, tl + 1, h);
      push(d, K_BIAS, tl + 2, 0);
      tv  = tl + 2 + lat;
      ths = tv + stall;
      push(d, K_VRISE, tv, 0);
      push(d, K_HS, ths, 0);
      push(d, K_CLR, ths + 1, 0);

      for (int i = 0; i < h; i++) begin
         drive(d, 1'b1, w[i], stall == 0);
         step();
         if (i == gap_idx) begin
            for (int g = 0; g < gap_len; g++) begin
               drive(d, 1'b0, 16'h7777, stall == 0);
               chk("gap mem_addr_o", (d == 0) ? int'(mem4) : int'(mem1), i + 1);
               step();
            end
         end
      end
      while (cyc < ths) begin
         drive(d, pulse && (cyc % 2 == 1), 16'h5555, stall == 0);
         step();
      end
      drive(d, 1'b0, 0, 1'b1);
      step();
      drive(d, 1'b0, 0, 1'b0);
      step();
      chk("post-clear ready_o", (d == 0) ? int'(rdy4) : int'(rdy1), 1);
      chk("post-clear busy_o", (d == 0) ? int'(bsy4) : int'(bsy1), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      step();

      send_vec(0, 4, 1, '{1, 2, 3, 4}, -1, 0, 0, 1'b0);
      send_vec(0, 4, 1, '{10, -3, 300, 7}, 1, 3, 0, 1'b0);
      send_vec(0, 4, 1, '{32767, -32768, 1, 2}, -1, 0, 10, 1'b1);
      send_vec(1, 1, 3, '{256, 0, 0, 0}, -1, 0, 0, 1'b0);
      step();

      // Abandon a vector after two words with an asynchronous reset.
      t0 = cyc;
      push(0, K_ACC, t0, 0);
      push(0, K_SUM, t0 + 1, 5);
      push(0, K_ACC, t0 + 1, 1);
      push(0, K_SUM, t0 + 2, 6);
      drive(0, 1'b1, 5, 1'b0);
      step();
      drive(0, 1'b1, 6, 1'b0);
      step();
      drive(0, 1'b0, 0, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async rst sum_en_o", int'(se4), 0);
      chk("async rst data_o", int'(do4), 0);
      chk("async rst mem_addr_o", int'(mem4), 0);
      chk("async rst neuron_reset_o", int'(nr4), 1);
      chk("async rst busy_o", int'(bsy4), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (8) step();
      send_vec(0, 4, 1, '{9, 8, 7, 6}, -1, 0, 0, 1'b0);

`ifdef FC_LAYER_SEQ_PERF_EN
      do_reset();
      send_vec(0, 4, 1, '{1, 1, 1, 1}, 1, 3, 2, 1'b0);
      send_vec(0, 4, 1, '{2, 2, 2, 2}, -1, 0, 0, 1'b0);
      chk("stall_cnt_o", int'(st4), 5);
      chk("vec_cnt_o", int'(vc4), 2);
`endif

      repeat (4) step();
      foreach (exp_q[i]) begin
         n_checks++;
         n_fail++;
         $display("FAIL dut%0d missing %s: never seen, required at cycle %0d value %0d",
                  exp_q[i].dut, kname(exp_q[i].kind), exp_q[i].cyc, exp_q[i].val);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
